// File: rtl/bpc_sc_decoder_if.sv
// Handshake and result bundle between the SC fabric/controller and bpc_sc_decoder.
// The decoder sits on the slave modport; the stream source and controller sit on the master modport.
interface bpc_sc_decoder_if #(
    parameter int unsigned W  = 6,
    parameter int unsigned N  = 2,
    parameter int unsigned PW = $clog2(W + 1)
);
    logic          start;
    logic [N-1:0]  Zs;
    logic          Zv;
    logic          stop;
    logic [W-1:0]  Bzs [N-1:0];
    logic [PW-1:0] prec;
    logic          valid;
    logic          busy;

    modport master (
        output start, Zs, Zv, stop,
        input  Bzs, prec, valid, busy
    );

    modport slave (
        input  start, Zs, Zv, stop,
        output Bzs, prec, valid, busy
    );
endinterface

// File: rtl/bpc_sc_decoder.sv
// Decodes N bit-plane-coded stochastic streams into W-bit binary values.
// Each stream's ones-count is snapshotted at every power-of-two length, so an early stop reports the best precision reached.
module bpc_sc_decoder #(
    parameter int unsigned W  = 6,
    parameter int unsigned N  = 2,
    parameter int unsigned PW = $clog2(W + 1)
) (
    input logic             clk,
    input logic             rst_n,
    bpc_sc_decoder_if.slave bus
);
    localparam int unsigned CW = W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt  [N];
    logic [CW-1:0] snap [N];
    logic [CW-1:0] k;
    logic [PW-1:0] sp;

    logic [CW-1:0] k_upd_c;
    logic [CW-1:0] cnt_upd_c  [N];
    logic [CW-1:0] snap_upd_c [N];
    logic [CW-1:0] shifted_c  [N];
    logic [W-1:0]  bzs_c      [N];
    logic          hit_c;
    logic [PW-1:0] hit_p_c;
    logic [PW-1:0] sp_upd_c;
    logic [PW-1:0] sh_c;
    logic          full_c;

    // Next-count, power-of-two snapshot and saturated rescale, all from the post-update values.
    always_comb begin
        k_upd_c = k + CW'(bus.Zv);
        hit_c   = 1'b0;
        hit_p_c = '0;
        for (int unsigned j = 0; j <= W; j++) begin
            if (bus.Zv && (k_upd_c == (CW'(1) << j))) begin
                hit_c   = 1'b1;
                hit_p_c = PW'(j);
            end
        end
        sp_upd_c = hit_c ? hit_p_c : sp;
        sh_c     = PW'(W) - sp_upd_c;
        full_c   = (k_upd_c == (CW'(1) << W));
        for (int unsigned i = 0; i < N; i++) begin
            cnt_upd_c[i]  = cnt[i] + CW'(bus.Zv & bus.Zs[i]);
            snap_upd_c[i] = hit_c ? cnt_upd_c[i] : snap[i];
            shifted_c[i]  = snap_upd_c[i] << sh_c;
            // A full-scale stream shifts to exactly 2^W; clamp to the largest W-bit value.
            bzs_c[i]      = shifted_c[i][W] ? {W{1'b1}} : shifted_c[i][W-1:0];
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            sp        <= '0;
            bus.prec  <= '0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i]     <= '0;
                snap[i]    <= '0;
                bus.Bzs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    bus.valid <= 1'b0;
                    if (bus.start) begin
                        k        <= '0;
                        sp       <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                        for (int unsigned i = 0; i < N; i++) begin
                            cnt[i]  <= '0;
                            snap[i] <= '0;
                        end
                    end
                end
                RUN: begin
                    k  <= k_upd_c;
                    sp <= sp_upd_c;
                    for (int unsigned i = 0; i < N; i++) begin
                        cnt[i]  <= cnt_upd_c[i];
                        snap[i] <= snap_upd_c[i];
                    end
                    // A bit arriving together with stop is counted before terminating.
                    if (full_c || bus.stop) begin
                        state     <= FIN;
                        bus.valid <= 1'b1;
                        bus.prec  <= sp_upd_c;
                        for (int unsigned i = 0; i < N; i++) begin
                            bus.Bzs[i] <= bzs_c[i];
                        end
                    end
                end
                FIN: begin
                    bus.valid <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bus.valid <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bpc_sc_decoder.sv
// Directed bench for bpc_sc_decoder: expected results are queued as each decode is driven and checked when valid pulses.
module tb_bpc_sc_decoder;
    localparam int unsigned W  = 6;
    localparam int unsigned N  = 2;
    localparam int unsigned PW = $clog2(W + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bpc_sc_decoder_if #(.W(W), .N(N), .PW(PW)) bif ();

    bpc_sc_decoder #(.W(W), .N(N), .PW(PW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    typedef struct packed {
        logic [W-1:0]  b0;
        logic [W-1:0]  b1;
        logic [PW-1:0] p;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0d expected %0d", tag, what, obs, exp);
        end
    endtask

    task automatic push_exp(input int b0, input int b1, input int p);
        exp_t e;
        e.b0 = W'(b0);
        e.b1 = W'(b1);
        e.p  = PW'(p);
        sb.push_back(e);
    endtask

    task automatic idle_in();
        bif.start = 1'b0;
        bif.Zs    = '0;
        bif.Zv    = 1'b0;
        bif.stop  = 1'b0;
    endtask

    task automatic drive(input logic st, input logic [N-1:0] zs, input logic zv, input logic sp);
        @(negedge clk);
        bif.start = st;
        bif.Zs    = zs;
        bif.Zv    = zv;
        bif.stop  = sp;
    endtask

    task automatic begin_decode();
        drive(1'b1, '0, 1'b0, 1'b0);
    endtask

    // Waits (bounded) for valid after the terminating input, then checks the queued result and the return to idle.
    task automatic finish_decode(input string tag);
        exp_t e;
        int   lat = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (bif.valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        idle_in();
        check(tag, "latency", 32'(lat), 32'd1);
        if (lat != 0) begin
            check(tag, "sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(tag, "Bzs0", 32'(bif.Bzs[0]), 32'(e.b0));
                check(tag, "Bzs1", 32'(bif.Bzs[1]), 32'(e.b1));
                check(tag, "prec", 32'(bif.prec), 32'(e.p));
                check(tag, "busy_fin", 32'(bif.busy), 32'd1);
                @(posedge clk);
                #1;
                check(tag, "valid_drop", 32'(bif.valid), 32'd0);
                check(tag, "busy_drop", 32'(bif.busy), 32'd0);
                check(tag, "Bzs0_hold", 32'(bif.Bzs[0]), 32'(e.b0));
                check(tag, "prec_hold", 32'(bif.prec), 32'(e.p));
            end
        end
    endtask

    initial begin
        logic saw_valid;
        idle_in();
        repeat (3) @(negedge clk);
        check("reset", "busy", 32'(bif.busy), 32'd0);
        check("reset", "valid", 32'(bif.valid), 32'd0);
        check("reset", "Bzs0", 32'(bif.Bzs[0]), 32'd0);
        check("reset", "prec", 32'(bif.prec), 32'd0);
        rst_n = 1'b1;

        // Full-length stream: stream 0 all ones, stream 1 alternating from 1.
        begin_decode();
        push_exp(63, 32, 6);
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, {1'(i % 2 == 0), 1'b1}, 1'b1, 1'b0);
            if (i == 30) check("full", "busy_run", 32'(bif.busy), 32'd1);
        end
        finish_decode("full");

        // Stop exactly at k=16.
        begin_decode();
        push_exp(16, 0, 4);
        for (int i = 0; i < 16; i++)
            drive(1'b0, {1'b0, 1'(i % 4 == 0)}, 1'b1, 1'(i == 15));
        finish_decode("stop16");

        // Stop at k=20: ones after the k=16 boundary are discarded.
        begin_decode();
        push_exp(16, 0, 4);
        for (int i = 0; i < 20; i++)
            drive(1'b0, {1'b0, 1'((i % 4 == 0) || (i >= 16))}, 1'b1, 1'(i == 19));
        finish_decode("stop20");

        // Zv gaps carrying ones must not count.
        begin_decode();
        push_exp(63, 63, 3);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b11, 1'b1, 1'b0);
            if (i < 5) drive(1'b0, 2'b11, 1'b0, 1'b0);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        finish_decode("gaps");

        begin_decode();
        push_exp(8, 0, 3);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, {1'b0, 1'(i == 0)}, 1'b1, 1'b0);
            if (i < 5) drive(1'b0, 2'b01, 1'b0, 1'b0);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        finish_decode("gaps_one");

        // Asynchronous reset at k=10 clears outputs at once and suppresses valid.
        begin_decode();
        for (int i = 0; i < 10; i++) drive(1'b0, 2'b11, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid", "busy", 32'(bif.busy), 32'd0);
        check("rst_mid", "valid", 32'(bif.valid), 32'd0);
        check("rst_mid", "Bzs0", 32'(bif.Bzs[0]), 32'd0);
        check("rst_mid", "prec", 32'(bif.prec), 32'd0);
        idle_in();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | bif.valid;
        end
        check("rst_mid", "no_valid", 32'(saw_valid), 32'd0);

        begin_decode();
        push_exp(63, 63, 2);
        for (int i = 0; i < 4; i++) drive(1'b0, 2'b11, 1'b1, 1'(i == 3));
        finish_decode("after_rst");

        // Stop on the first RUN cycle with no valid data.
        begin_decode();
        push_exp(0, 0, 0);
        drive(1'b0, 2'b11, 1'b0, 1'b1);
        finish_decode("stop_empty");

        // A start pulse during RUN must not restart the count.
        begin_decode();
        push_exp(63, 0, 3);
        for (int i = 0; i < 8; i++) drive(1'(i == 2), 2'b01, 1'b1, 1'(i == 7));
        finish_decode("start_busy");

        check("end", "sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
